// File: rtl/multicycle_control_if.sv
// Bundle between the multicycle controller and its datapath: instruction fields and
// memory handshake into the controller, mux selects, strobes and status out of it.
interface multicycle_control_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic       ALUSrcA;
    logic       RegWrite;
    logic [1:0] PCSource;
    logic [1:0] ALUSrcB;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic [2:0] ALUOp;
    logic       InstrDone;
    logic       Fault;
    logic [3:0] State;

    modport master (
        input  Op, Funct, Zero, MemReady,
        output IorD, MemRead, MemWrite, IRWrite, PCWrite, ALUSrcA, RegWrite,
        output PCSource, ALUSrcB, RegDst, MemtoReg, ALUOp, InstrDone, Fault, State
    );

    modport slave (
        output Op, Funct, Zero, MemReady,
        input  IorD, MemRead, MemWrite, IRWrite, PCWrite, ALUSrcA, RegWrite,
        input  PCSource, ALUSrcB, RegDst, MemtoReg, ALUOp, InstrDone, Fault, State
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style main controller: Moore FSM with Mealy memory-ready qualification,
// a shared-memory wait watchdog, and fault handling for illegal opcodes and timeouts.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXEC = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13,
        S_FAULT  = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam int              WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                timeout_s;

    logic       iord_s, mem_read_s, mem_write_s, ir_write_s, pc_write_s, alu_src_a_s, reg_write_s;
    logic [1:0] pc_source_s, alu_src_b_s, reg_dst_s, memto_reg_s;
    logic [2:0] alu_op_s;
    logic       instr_done_s, fault_s;

    function automatic logic is_wait_state(input state_t st);
        return (st == S_FETCH) || (st == S_MEMRD) || (st == S_MEMWR);
    endfunction

    // State and wait-counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic; memory-ready in the last allowed cycle wins over the timeout.
    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        timeout_s = (wait_q == WAIT_LAST) && !bus.MemReady;
        case (state_q)
            S_FETCH: begin
                if (bus.MemReady)   state_d = S_DECODE;
                else if (timeout_s) state_d = S_FAULT;
                else                state_d = S_FETCH;
            end
            S_DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW:                     state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (bus.Funct == FN_JR) state_d = S_JR;
                        else                    state_d = S_RTEXEC;
                    end
                    OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_IEXEC;
                    OP_J:                             state_d = S_JUMP;
                    OP_JAL:                           state_d = S_JAL;
                    default:                          state_d = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                if (bus.Op == OP_LW) state_d = S_MEMRD;
                else                 state_d = S_MEMWR;
            end
            S_MEMRD: begin
                if (bus.MemReady)   state_d = S_MEMWB;
                else if (timeout_s) state_d = S_FAULT;
                else                state_d = S_MEMRD;
            end
            S_MEMWR: begin
                if (bus.MemReady)   state_d = S_FETCH;
                else if (timeout_s) state_d = S_FAULT;
                else                state_d = S_MEMWR;
            end
            S_RTEXEC: state_d = S_RTWB;
            S_IEXEC:  state_d = S_IWB;
            S_MEMWB, S_RTWB, S_BRANCH, S_IWB, S_JUMP, S_JAL, S_JR, S_FAULT: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
        // The counter only survives while a memory-wait state holds; any transition clears it.
        if ((state_d == state_q) && is_wait_state(state_q)) begin
            wait_d = wait_q + WAIT_W'(1);
        end else begin
            wait_d = '0;
        end
    end

    // Moore output decode, with FETCH latch enables and MEMWR retire qualified by MemReady.
    always_comb begin
        iord_s       = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        alu_src_a_s  = 1'b0;
        reg_write_s  = 1'b0;
        pc_source_s  = 2'd0;
        alu_src_b_s  = 2'd0;
        reg_dst_s    = 2'd0;
        memto_reg_s  = 2'd0;
        alu_op_s     = 3'b000;
        instr_done_s = 1'b0;
        fault_s      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = 2'd1;
                ir_write_s  = bus.MemReady;
                pc_write_s  = bus.MemReady;
            end
            S_DECODE: alu_src_b_s = 2'd3;
            S_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'd2;
            end
            S_MEMRD: begin
                iord_s     = 1'b1;
                mem_read_s = 1'b1;
            end
            S_MEMWB: begin
                reg_write_s  = 1'b1;
                memto_reg_s  = 2'd1;
                instr_done_s = 1'b1;
            end
            S_MEMWR: begin
                iord_s       = 1'b1;
                mem_write_s  = 1'b1;
                instr_done_s = bus.MemReady;
            end
            S_RTEXEC: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = 3'b010;
            end
            S_RTWB: begin
                reg_write_s  = 1'b1;
                reg_dst_s    = 2'd1;
                instr_done_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_s  = 1'b1;
                alu_op_s     = 3'b001;
                pc_source_s  = 2'd1;
                pc_write_s   = ((bus.Op == OP_BEQ) && bus.Zero) || ((bus.Op == OP_BNE) && !bus.Zero);
                instr_done_s = 1'b1;
            end
            S_IEXEC: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'd2;
                case (bus.Op)
                    OP_ORI:  alu_op_s = 3'b011;
                    OP_ANDI: alu_op_s = 3'b100;
                    OP_LUI:  alu_op_s = 3'b101;
                    default: alu_op_s = 3'b000;
                endcase
            end
            S_IWB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_JUMP: begin
                pc_write_s   = 1'b1;
                pc_source_s  = 2'd2;
                instr_done_s = 1'b1;
            end
            S_JR: begin
                pc_write_s   = 1'b1;
                pc_source_s  = 2'd3;
                instr_done_s = 1'b1;
            end
            S_JAL: begin
                pc_write_s   = 1'b1;
                pc_source_s  = 2'd2;
                reg_write_s  = 1'b1;
                reg_dst_s    = 2'd2;
                memto_reg_s  = 2'd2;
                instr_done_s = 1'b1;
            end
            S_FAULT: fault_s = 1'b1;
            default: fault_s = 1'b0;
        endcase
    end

    // Drive the bus; everything is held quiet while reset is asserted.
    always_comb begin
        bus.State = state_q;
        if (reset) begin
            bus.IorD      = 1'b0;
            bus.MemRead   = 1'b0;
            bus.MemWrite  = 1'b0;
            bus.IRWrite   = 1'b0;
            bus.PCWrite   = 1'b0;
            bus.ALUSrcA   = 1'b0;
            bus.RegWrite  = 1'b0;
            bus.PCSource  = 2'd0;
            bus.ALUSrcB   = 2'd0;
            bus.RegDst    = 2'd0;
            bus.MemtoReg  = 2'd0;
            bus.ALUOp     = 3'b000;
            bus.InstrDone = 1'b0;
            bus.Fault     = 1'b0;
        end else begin
            bus.IorD      = iord_s;
            bus.MemRead   = mem_read_s;
            bus.MemWrite  = mem_write_s;
            bus.IRWrite   = ir_write_s;
            bus.PCWrite   = pc_write_s;
            bus.ALUSrcA   = alu_src_a_s;
            bus.RegWrite  = reg_write_s;
            bus.PCSource  = pc_source_s;
            bus.ALUSrcB   = alu_src_b_s;
            bus.RegDst    = reg_dst_s;
            bus.MemtoReg  = memto_reg_s;
            bus.ALUOp     = alu_op_s;
            bus.InstrDone = instr_done_s;
            bus.Fault     = fault_s;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench: each instruction is expanded into its expected per-cycle state trace,
// then driven cycle by cycle and every output is compared against the trace.
module tb_multicycle_control;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control #(.MEM_TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int st;
        bit mr;
        bit done;
    } cyc_t;

    cyc_t plan[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic push(input int st, input bit mr, input bit done);
        cyc_t c;
        c.st = st;
        c.mr = mr;
        c.done = done;
        plan.push_back(c);
    endtask

    // A memory wait: wt idle cycles then the ready cycle, or a timeout into FAULT.
    task automatic add_wait(input int st, input int wt, input bit done_on_ready, output bit faulted);
        faulted = 1'b0;
        if (wt >= TO) begin
            for (int i = 0; i < TO; i++) push(st, 1'b0, 1'b0);
            push(14, 1'($urandom_range(0, 1)), 1'b0);
            faulted = 1'b1;
        end else begin
            for (int i = 0; i < wt; i++) push(st, 1'b0, 1'b0);
            push(st, 1'b1, done_on_ready);
        end
    endtask

    function automatic bit uses_op(input int st);
        return (st == 1) || (st == 2) || (st == 8) || (st == 9);
    endfunction

    // Expected outputs of one cycle given the state the trace says we are in.
    task automatic exp_out(input int st, input logic [5:0] op, input bit z, input bit mr, input bit done,
                           output logic [6:0] stb, output logic [12:0] sel, output logic [12:0] msk);
        logic rd_, wr_, irw, pcw, rw, iord, asa;
        logic [1:0] pcs, asb, rdst, m2r;
        logic [2:0] aop;
        bit k_iord, k_asa, k_pcs, k_asb, k_rdst, k_m2r, k_aop;
        {rd_, wr_, irw, pcw, rw, iord, asa} = 7'b0;
        {pcs, asb, rdst, m2r, aop} = 11'b0;
        {k_iord, k_asa, k_pcs, k_asb, k_rdst, k_m2r, k_aop} = 7'b0;
        case (st)
            0: begin rd_ = 1; irw = mr; pcw = mr; iord = 0; asa = 0; asb = 1; aop = 0; pcs = 0;
                     k_iord = 1; k_asa = 1; k_asb = 1; k_aop = 1; k_pcs = 1; end
            1: begin asa = 0; asb = 3; aop = 0; k_asa = 1; k_asb = 1; k_aop = 1; end
            2: begin asa = 1; asb = 2; aop = 0; k_asa = 1; k_asb = 1; k_aop = 1; end
            3: begin iord = 1; rd_ = 1; k_iord = 1; end
            4: begin rw = 1; rdst = 0; m2r = 1; k_rdst = 1; k_m2r = 1; end
            5: begin iord = 1; wr_ = 1; k_iord = 1; end
            6: begin asa = 1; asb = 0; aop = 2; k_asa = 1; k_asb = 1; k_aop = 1; end
            7: begin rw = 1; rdst = 1; m2r = 0; k_rdst = 1; k_m2r = 1; end
            8: begin asa = 1; asb = 0; aop = 1; pcs = 1; k_asa = 1; k_asb = 1; k_aop = 1; k_pcs = 1;
                     pcw = ((op == 6'h04) && z) || ((op == 6'h05) && !z); end
            9: begin asa = 1; asb = 2; k_asa = 1; k_asb = 1; k_aop = 1;
                     aop = (op == 6'h0D) ? 3'd3 : (op == 6'h0C) ? 3'd4 : (op == 6'h0F) ? 3'd5 : 3'd0; end
            10: begin rw = 1; rdst = 0; m2r = 0; k_rdst = 1; k_m2r = 1; end
            11: begin pcw = 1; pcs = 2; k_pcs = 1; end
            12: begin pcw = 1; pcs = 2; rw = 1; rdst = 2; m2r = 2; k_pcs = 1; k_rdst = 1; k_m2r = 1; end
            13: begin pcw = 1; pcs = 3; k_pcs = 1; end
            default: begin end
        endcase
        stb = {rd_, wr_, irw, pcw, rw, done, (st == 14)};
        sel = {iord, asa, pcs, asb, rdst, m2r, aop};
        msk = {k_iord, k_asa, {2{k_pcs}}, {2{k_asb}}, {2{k_rdst}}, {2{k_m2r}}, {3{k_aop}}};
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b1;
            bus.MemReady = 1'($urandom_range(0, 1));
            bus.Op = 6'($urandom);
            #1;
            check_eq("rst_strobes", {bus.MemRead, bus.MemWrite, bus.IRWrite, bus.PCWrite,
                                     bus.RegWrite, bus.InstrDone, bus.Fault}, 32'd0);
            if (i > 0) check_eq("rst_state", bus.State, 32'd0);
        end
    endtask

    // Build the expected trace for one instruction, then drive and check it.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                             input int fw, input int mw, input int abort_at);
        bit f;
        logic [6:0]  stb;
        logic [12:0] sel, msk, sel_obs;
        plan.delete();
        add_wait(0, fw, 1'b0, f);
        if (!f) begin
            push(1, 1'($urandom_range(0, 1)), 1'b0);
            case (op)
                6'h23: begin
                    push(2, 1'($urandom_range(0, 1)), 1'b0);
                    add_wait(3, mw, 1'b0, f);
                    if (!f) push(4, 1'($urandom_range(0, 1)), 1'b1);
                end
                6'h2B: begin
                    push(2, 1'($urandom_range(0, 1)), 1'b0);
                    add_wait(5, mw, 1'b1, f);
                end
                6'h00: begin
                    if (fn == 6'h08) push(13, 1'b0, 1'b1);
                    else begin push(6, 1'b0, 1'b0); push(7, 1'b1, 1'b1); end
                end
                6'h04, 6'h05: push(8, 1'($urandom_range(0, 1)), 1'b1);
                6'h08, 6'h0C, 6'h0D, 6'h0F: begin push(9, 1'b1, 1'b0); push(10, 1'b0, 1'b1); end
                6'h02: push(11, 1'b1, 1'b1);
                6'h03: push(12, 1'b0, 1'b1);
                default: push(14, 1'b1, 1'b0);
            endcase
        end
        for (int i = 0; i < plan.size(); i++) begin
            if (abort_at >= 0 && i == abort_at) break;
            @(negedge clk);
            reset = 1'b0;
            bus.MemReady = plan[i].mr;
            bus.Zero  = (plan[i].st == 8) ? z : 1'($urandom_range(0, 1));
            bus.Op    = uses_op(plan[i].st) ? op : 6'($urandom);
            bus.Funct = uses_op(plan[i].st) ? fn : 6'($urandom);
            #1;
            exp_out(plan[i].st, op, z, plan[i].mr, plan[i].done, stb, sel, msk);
            sel_obs = {bus.IorD, bus.ALUSrcA, bus.PCSource, bus.ALUSrcB, bus.RegDst, bus.MemtoReg, bus.ALUOp};
            check_eq($sformatf("state op=%0h cyc%0d", op, i), bus.State, plan[i].st);
            check_eq($sformatf("strobes st=%0d op=%0h", plan[i].st, op),
                     {bus.MemRead, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegWrite,
                      bus.InstrDone, bus.Fault}, stb);
            check_eq($sformatf("selects st=%0d op=%0h", plan[i].st, op), sel_obs & msk, sel & msk);
        end
    endtask

    logic [5:0] legal_ops [12] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
                                   6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};

    initial begin
        reset = 1'b1;
        bus.Op = 6'h00; bus.Funct = 6'h00; bus.Zero = 1'b0; bus.MemReady = 1'b0;
        do_reset(3);

        run_instr(6'h00, 6'h20, 1'b0, 0, 0, -1);   // add
        run_instr(6'h23, 6'h00, 1'b0, 0, 3, -1);   // lw, three idle memory cycles
        run_instr(6'h04, 6'h00, 1'b1, 1, 0, -1);   // beq taken
        run_instr(6'h04, 6'h00, 1'b0, 0, 0, -1);   // beq not taken
        run_instr(6'h05, 6'h00, 1'b1, 0, 0, -1);   // bne not taken
        run_instr(6'h05, 6'h00, 1'b0, 2, 0, -1);   // bne taken
        run_instr(6'h03, 6'h00, 1'b0, 0, 0, -1);   // jal
        run_instr(6'h3F, 6'h00, 1'b0, 0, 0, -1);   // illegal opcode
        run_instr(6'h00, 6'h20, 1'b0, TO, 0, -1);  // fetch timeout
        run_instr(6'h00, 6'h20, 1'b0, TO - 1, 0, -1); // ready in last allowed cycle
        run_instr(6'h23, 6'h00, 1'b0, 0, TO, -1);  // read timeout
        run_instr(6'h2B, 6'h00, 1'b0, 0, TO - 1, -1);
        run_instr(6'h00, 6'h08, 1'b0, 0, 0, -1);   // jr
        run_instr(6'h02, 6'h00, 1'b0, 0, 0, -1);   // j
        run_instr(6'h08, 6'h00, 1'b0, 0, 0, -1);
        run_instr(6'h0C, 6'h00, 1'b0, 0, 0, -1);
        run_instr(6'h0D, 6'h00, 1'b0, 0, 0, -1);
        run_instr(6'h0F, 6'h00, 1'b0, 0, 0, -1);
        run_instr(6'h2B, 6'h00, 1'b0, 0, 5, 5);    // sw aborted mid-wait by reset
        do_reset(1);
        run_instr(6'h00, 6'h20, 1'b0, 0, 0, -1);

        for (int n = 0; n < 80; n++) begin
            logic [5:0] op;
            logic [5:0] fn;
            int fw;
            int mw;
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 11)];
            fn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
            fw = ($urandom_range(0, 15) == 0) ? TO : $urandom_range(0, 3);
            mw = ($urandom_range(0, 15) == 0) ? TO : $urandom_range(0, 4);
            run_instr(op, fn, 1'($urandom_range(0, 1)), fw, mw, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
